// File: rtl/pipe_load_reader.sv
// pipe_load_reader: two-stage load pipeline, data memory -> register bank.
// Ports: req_* load request in, resp_* loaded word out, mem_* preload write,
//        rb_* bank debug read, load_count completed loads (8-bit wrap).
module pipe_load_reader #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [RW-1:0] req_rd,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_data,
  output logic [RW-1:0] resp_rd,
  input  logic [RW-1:0] rb_raddr,
  output logic [DW-1:0] rb_rdata,
  output logic [7:0]    load_count
);

  localparam int MD = 1 << AW;
  localparam int RD = 1 << RW;

  logic [DW-1:0] mem  [MD];
  logic [DW-1:0] bank [RD];

  logic          s1_valid;
  logic [AW-1:0] s1_addr;
  logic [RW-1:0] s1_rd;

  logic adv1;
  logic adv2;
  logic accept;
  logic retire;
  logic fwd;

  assign adv2      = !resp_valid || resp_ready;
  assign adv1      = !s1_valid || adv2;
  assign req_ready = adv1;
  assign accept    = req_valid && adv1;
  assign retire    = resp_valid && resp_ready;

  // A write landing on the edge that captures the read wins over old data.
  assign fwd = mem_we && (mem_waddr == s1_addr);

  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv1) begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= req_addr;
        s1_rd   <= req_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
    end else if (adv2) begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_data <= fwd ? mem_wdata : mem[s1_addr];
        resp_rd   <= s1_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_count <= 8'd0;
    end else if (retire) begin
      load_count <= load_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD; i++) begin
        bank[i] <= '0;
      end
    end else if (retire) begin
      bank[resp_rd] <= resp_data;
    end
  end

  assign rb_rdata = bank[rb_raddr];

endmodule

// File: tb/tb_pipe_load_reader.sv
// tb_pipe_load_reader: scoreboard bench for pipe_load_reader.
// Expected words queued at accept, popped when a response retires.
module tb_pipe_load_reader;

  logic        clk = 0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_rd;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [15:0] mem_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [3:0]  resp_rd;
  logic [3:0]  rb_raddr;
  logic [15:0] rb_rdata;
  logic [7:0]  load_count;

  pipe_load_reader dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_rd     (req_rd),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_rd    (resp_rd),
    .rb_raddr   (rb_raddr),
    .rb_rdata   (rb_rdata),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] d;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] mem_m [256];
  logic [15:0] rb_m  [16];
  logic [7:0]  cnt_m;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_data", resp_data, e.d);
        chk("resp_rd", resp_rd, e.rd);
        rb_m[e.rd] = e.d;
        cnt_m = cnt_m + 8'd1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mem_wr(input logic [7:0] a, input logic [15:0] d);
    mem_we = 1; mem_waddr = a; mem_wdata = d;
    tick;
    mem_we = 0;
    mem_m[a] = d;
  endtask

  task automatic do_load(input logic [7:0] a, input logic [3:0] rd,
                         input bit push);
    int n;
    n = 0;
    req_valid = 1; req_addr = a; req_rd = rd;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_timeout", 32'd0, 32'd1);
    else if (push) sb.push_back('{rd, mem_m[a]});
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic drain;
    repeat (4) tick;
    chk("sb_drain", sb.size(), 32'd0);
  endtask

  task automatic rb_check;
    for (int i = 0; i < 16; i++) begin
      rb_raddr = 4'(i);
      #1;
      chk("rb", rb_rdata, rb_m[i]);
    end
    tick;
  endtask

  initial begin
    logic [7:0] c0;
    rst = 1; req_valid = 0; req_addr = 0; req_rd = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0;
    resp_ready = 1; rb_raddr = 0; cnt_m = 0;
    for (int i = 0; i < 16; i++) rb_m[i] = 16'h0;
    tick; tick;
    rst = 0;
    chk("rst_valid", resp_valid, 32'd0);
    chk("rst_ready", req_ready, 32'd1);
    chk("rst_cnt", load_count, 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_rd", resp_rd, 32'd0);

    for (int i = 0; i < 256; i++)
      mem_wr(8'(i), 16'(i * 257) ^ 16'h5a3c);
    mem_wr(8'd125, 16'h0009);
    mem_wr(8'd126, 16'h0018);
    mem_wr(8'd127, 16'h0005);
    mem_wr(8'd255, 16'hbeef);

    // in-order loads, 1-cycle latency
    do_load(8'd125, 4'd10, 1);
    chk("lat_early", resp_valid, 32'd0);
    do_load(8'd126, 4'd12, 1);
    chk("lat_valid", resp_valid, 32'd1);
    chk("lat_data", resp_data, 32'h0009);
    do_load(8'd127, 4'd14, 1);
    drain;
    rb_raddr = 4'd10; #1; chk("rb10", rb_rdata, 32'h0009);
    rb_raddr = 4'd12; #1; chk("rb12", rb_rdata, 32'h0018);
    rb_raddr = 4'd14; #1; chk("rb14", rb_rdata, 32'h0005);
    chk("cnt3", load_count, 32'd3);
    tick;

    // backpressure
    resp_ready = 0;
    do_load(8'd20, 4'd1, 1);
    do_load(8'd21, 4'd2, 1);
    chk("full_ready", req_ready, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", resp_valid, 32'd1);
      chk("stall_data", resp_data, mem_m[20]);
      tick;
    end
    resp_ready = 1;
    drain;
    chk("bp_cnt", load_count, cnt_m);

    // forwarding on the read-capture edge
    mem_wr(8'd40, 16'h1111);
    do_load(8'd40, 4'd3, 0);
    sb.push_back('{4'd3, 16'h2222});
    mem_wr(8'd40, 16'h2222);
    do_load(8'd40, 4'd4, 1);
    drain;
    rb_check;

    // reset with both stages full
    resp_ready = 0;
    do_load(8'd10, 4'd5, 1);
    do_load(8'd11, 4'd6, 1);
    chk("pre_rst_full", req_ready, 32'd0);
    rst = 1;
    tick;
    rst = 0;
    sb.delete();
    for (int i = 0; i < 16; i++) rb_m[i] = 16'h0;
    cnt_m = 0;
    chk("mid_rst_valid", resp_valid, 32'd0);
    chk("mid_rst_ready", req_ready, 32'd1);
    chk("mid_rst_cnt", load_count, 32'd0);
    rb_check;
    resp_ready = 1;
    do_load(8'd125, 4'd7, 1);
    drain;
    rb_raddr = 4'd7; #1; chk("mem_kept", rb_rdata, 32'h0009);
    tick;

    // 256 loads wrap the counter back to its start value
    c0 = load_count;
    for (int i = 0; i < 256; i++)
      do_load(8'(i), 4'(i), 1);
    drain;
    chk("wrap_cnt", load_count, c0);
    chk("wrap_model", load_count, cnt_m);
    rb_raddr = 4'd15; #1; chk("addr255", rb_rdata, 32'hbeef);
    tick;

    // idle
    for (int i = 0; i < 6; i++) begin
      chk("idle_valid", resp_valid, 32'd0);
      tick;
    end
    rb_check;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
